// File: rtl/piano_pkg.sv
// Shared encodings, note constants and song tables for the piano mode controller.
package piano_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_LEARN  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_MANUAL,
        ST_PLAY,
        ST_GAP,
        ST_LEARN
    } state_e;

    typedef enum logic {
        SONG_ODE,
        SONG_DOREMI
    } song_e;

    localparam logic [2:0] C  = 3'd0;
    localparam logic [2:0] D  = 3'd1;
    localparam logic [2:0] E  = 3'd2;
    localparam logic [2:0] F  = 3'd3;
    localparam logic [2:0] G  = 3'd4;
    localparam logic [2:0] A  = 3'd5;
    localparam logic [2:0] B  = 3'd6;
    localparam logic [2:0] HC = 3'd7;

    localparam int ODE_LEN    = 15;
    localparam int DOREMI_LEN = 14;

    localparam logic [4:0] ODE_LAST    = 5'(ODE_LEN - 1);
    localparam logic [4:0] DOREMI_LAST = 5'(DOREMI_LEN - 1);

    localparam logic [2:0] ODE_SONG [ODE_LEN] =
        '{E, E, F, G, G, F, E, D, C, C, D, E, E, D, D};
    localparam logic [2:0] DOREMI_SONG [DOREMI_LEN] =
        '{C, D, E, C, E, C, E, D, E, F, F, E, D, F};

    function automatic logic [2:0] song_note(input song_e sel, input logic [4:0] pos);
        logic [2:0] n;
        n = C;
        if (sel == SONG_ODE) begin
            if (pos <= ODE_LAST) n = ODE_SONG[pos[3:0]];
        end else begin
            if (pos <= DOREMI_LAST) n = DOREMI_SONG[pos[3:0]];
        end
        return n;
    endfunction

    function automatic logic [4:0] song_last(input song_e sel);
        return (sel == SONG_ODE) ? ODE_LAST : DOREMI_LAST;
    endfunction

    // Highest set key bit is the lowest pitch; later iterations override earlier ones.
    function automatic logic [2:0] key_to_idx(input logic [7:0] keys);
        logic [2:0] idx;
        idx = C;
        for (int k = 0; k < 8; k++) begin
            if (keys[k]) idx = 3'(7 - k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/piano_mode_ctrl_if.sv
// Button/key inputs and tone/feedback outputs of the piano mode controller.
interface piano_mode_ctrl_if;
    logic       ODE_TO_JOY_AUTO;
    logic       DOREMI_AUTO;
    logic       DOREMI_LEARN;
    logic [7:0] sw;
    logic       note_on;
    logic [2:0] note_idx;
    logic [2:0] expect_idx;
    logic [1:0] mode;
    logic [4:0] song_pos;
    logic       learn_ok;
    logic       learn_err;
    logic       done;

    modport master (
        output ODE_TO_JOY_AUTO, DOREMI_AUTO, DOREMI_LEARN, sw,
        input  note_on, note_idx, expect_idx, mode, song_pos, learn_ok, learn_err, done
    );

    modport slave (
        input  ODE_TO_JOY_AUTO, DOREMI_AUTO, DOREMI_LEARN, sw,
        output note_on, note_idx, expect_idx, mode, song_pos, learn_ok, learn_err, done
    );
endinterface

// File: rtl/piano_edge_det.sv
// Rising-edge detector: pulses while the input is high and its previous sample was low.
module piano_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= d;
    end

    assign rise = d & ~prev;
endmodule

// File: rtl/piano_mode_ctrl.sv
// Piano mode controller: manual play, song autoplay and guided learn mode.
module piano_mode_ctrl
    import piano_pkg::*;
#(
    parameter int TICKS_PER_NOTE = 4,
    parameter int GAP_TICKS      = 1
) (
    input logic              CLK,
    input logic              RESET_N,
    piano_mode_ctrl_if.slave bus
);
    localparam int MAX_TICKS = (TICKS_PER_NOTE > GAP_TICKS) ? TICKS_PER_NOTE : GAP_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] TICKS_C = CW'(TICKS_PER_NOTE);
    localparam logic [CW-1:0] GAP_C   = CW'(GAP_TICKS);

    logic ode_rise, dra_rise, drl_rise, key_rise, any_btn;

    piano_edge_det u_ode (.clk(CLK), .rst_n(RESET_N), .d(bus.ODE_TO_JOY_AUTO), .rise(ode_rise));
    piano_edge_det u_dra (.clk(CLK), .rst_n(RESET_N), .d(bus.DOREMI_AUTO),     .rise(dra_rise));
    piano_edge_det u_drl (.clk(CLK), .rst_n(RESET_N), .d(bus.DOREMI_LEARN),    .rise(drl_rise));
    piano_edge_det u_key (.clk(CLK), .rst_n(RESET_N), .d(|bus.sw),             .rise(key_rise));

    assign any_btn = ode_rise | dra_rise | drl_rise;

    state_e        state, state_d;
    song_e         sel, sel_d;
    logic [4:0]    pos, pos_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          note_on, note_on_d;
    logic [2:0]    note_idx, note_idx_d;
    logic [2:0]    expect_idx, expect_d;
    logic [1:0]    mode, mode_d;
    logic          ok, ok_d, err, err_d, done, done_d;
    logic          adv;
    logic [2:0]    pressed;

    assign pressed = key_to_idx(bus.sw);

    always_comb begin
        state_d    = state;
        sel_d      = sel;
        pos_d      = pos;
        cnt_d      = cnt;
        note_on_d  = 1'b0;
        note_idx_d = note_idx;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        done_d     = 1'b0;
        adv        = 1'b0;

        case (state)
            ST_MANUAL: begin
                note_on_d  = |bus.sw;
                note_idx_d = pressed;
                if (ode_rise || dra_rise) begin
                    sel_d      = ode_rise ? SONG_ODE : SONG_DOREMI;
                    state_d    = ST_PLAY;
                    pos_d      = '0;
                    cnt_d      = CW'(1);
                    note_on_d  = 1'b1;
                    note_idx_d = song_note(sel_d, 5'd0);
                end else if (drl_rise) begin
                    sel_d   = SONG_DOREMI;
                    state_d = ST_LEARN;
                    pos_d   = '0;
                end
            end
            ST_PLAY: begin
                note_on_d  = 1'b1;
                note_idx_d = song_note(sel, pos);
                if (cnt == TICKS_C) begin
                    if (GAP_TICKS == 0) begin
                        adv = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        cnt_d     = CW'(1);
                        note_on_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt == GAP_C) adv = 1'b1;
                else              cnt_d = cnt + CW'(1);
            end
            ST_LEARN: begin
                note_on_d  = |bus.sw;
                note_idx_d = pressed;
                if (key_rise) begin
                    if (pressed == song_note(sel, pos)) begin
                        ok_d = 1'b1;
                        if (pos == song_last(sel)) begin
                            done_d  = 1'b1;
                            state_d = ST_MANUAL;
                            pos_d   = '0;
                        end else begin
                            pos_d = pos + 5'd1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_MANUAL;
        endcase

        // End of a note's gap: either move to the next note or finish the song.
        if (adv) begin
            if (pos == song_last(sel)) begin
                done_d     = 1'b1;
                state_d    = ST_MANUAL;
                pos_d      = '0;
                cnt_d      = '0;
                note_on_d  = 1'b0;
                note_idx_d = C;
            end else begin
                pos_d      = pos + 5'd1;
                state_d    = ST_PLAY;
                cnt_d      = CW'(1);
                note_on_d  = 1'b1;
                note_idx_d = song_note(sel, pos_d);
            end
        end

        // Any button edge during a song returns to idle without starting a new mode.
        if (state != ST_MANUAL && any_btn) begin
            state_d    = ST_MANUAL;
            pos_d      = '0;
            cnt_d      = '0;
            note_on_d  = 1'b0;
            note_idx_d = C;
            ok_d       = 1'b0;
            err_d      = 1'b0;
            done_d     = 1'b0;
        end

        case (state_d)
            ST_PLAY, ST_GAP: mode_d = MODE_AUTO;
            ST_LEARN:        mode_d = MODE_LEARN;
            default:         mode_d = MODE_MANUAL;
        endcase
        expect_d = (state_d == ST_LEARN) ? song_note(sel_d, pos_d) : C;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= ST_MANUAL;
            sel        <= SONG_ODE;
            pos        <= '0;
            cnt        <= '0;
            note_on    <= 1'b0;
            note_idx   <= '0;
            expect_idx <= '0;
            mode       <= MODE_MANUAL;
            ok         <= 1'b0;
            err        <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            sel        <= sel_d;
            pos        <= pos_d;
            cnt        <= cnt_d;
            note_on    <= note_on_d;
            note_idx   <= note_idx_d;
            expect_idx <= expect_d;
            mode       <= mode_d;
            ok         <= ok_d;
            err        <= err_d;
            done       <= done_d;
        end
    end

    assign bus.note_on    = note_on;
    assign bus.note_idx   = note_idx;
    assign bus.expect_idx = expect_idx;
    assign bus.mode       = mode;
    assign bus.song_pos   = pos;
    assign bus.learn_ok   = ok;
    assign bus.learn_err  = err;
    assign bus.done       = done;
endmodule

// File: tb/tb_piano_mode_ctrl.sv
// Directed bench for piano_mode_ctrl: manual play, autoplay, abort, learn mode and reset.
module tb_piano_mode_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    piano_mode_ctrl_if bus ();

    piano_mode_ctrl #(.TICKS_PER_NOTE(4), .GAP_TICKS(1)) dut (
        .CLK    (clk),
        .RESET_N(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int ode_tbl [15] = '{2, 2, 3, 4, 4, 3, 2, 1, 0, 0, 1, 2, 2, 1, 1};
    int dre_tbl [14] = '{0, 1, 2, 0, 2, 0, 2, 1, 2, 3, 3, 2, 1, 3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, ".mode"},     int'(bus.mode), 0);
        check({tag, ".pos"},      int'(bus.song_pos), 0);
        check({tag, ".note_on"},  int'(bus.note_on), 0);
        check({tag, ".note_idx"}, int'(bus.note_idx), 0);
        check({tag, ".expect"},   int'(bus.expect_idx), 0);
        check({tag, ".ok"},       int'(bus.learn_ok), 0);
        check({tag, ".err"},      int'(bus.learn_err), 0);
        check({tag, ".done"},     int'(bus.done), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ODE_TO_JOY_AUTO = 1'b0;
        bus.DOREMI_AUTO     = 1'b0;
        bus.DOREMI_LEARN    = 1'b0;
        bus.sw              = 8'h00;
        tick();
        tick();
        check_idle_reset("reset");

        rst_n = 1'b1;
        tick();
        check("idle.mode", int'(bus.mode), 0);
        check("idle.note_on", int'(bus.note_on), 0);

        // Manual play: lowest pitch wins.
        bus.sw = 8'h24;
        tick();
        check("man24.note_on", int'(bus.note_on), 1);
        check("man24.note_idx", int'(bus.note_idx), 2);
        bus.sw = 8'h01;
        tick();
        check("man01.note_idx", int'(bus.note_idx), 7);
        bus.sw = 8'h00;
        tick();
        check("man00.note_on", int'(bus.note_on), 0);
        check("man00.note_idx", int'(bus.note_idx), 0);

        // Simultaneous ODE and DOREMI_AUTO edges: ODE plays in full.
        bus.ODE_TO_JOY_AUTO = 1'b1;
        bus.DOREMI_AUTO     = 1'b1;
        tick();
        bus.ODE_TO_JOY_AUTO = 1'b0;
        bus.DOREMI_AUTO     = 1'b0;
        for (int n = 0; n < 15; n++) begin
            for (int t = 0; t < 4; t++) begin
                if (!(n == 0 && t == 0)) tick();
                check($sformatf("ode.n%0d.t%0d.on", n, t), int'(bus.note_on), 1);
                check($sformatf("ode.n%0d.t%0d.idx", n, t), int'(bus.note_idx), ode_tbl[n]);
                check($sformatf("ode.n%0d.t%0d.pos", n, t), int'(bus.song_pos), n);
                check($sformatf("ode.n%0d.t%0d.mode", n, t), int'(bus.mode), 1);
                check($sformatf("ode.n%0d.t%0d.done", n, t), int'(bus.done), 0);
            end
            tick();
            check($sformatf("ode.n%0d.gap.on", n), int'(bus.note_on), 0);
            check($sformatf("ode.n%0d.gap.mode", n), int'(bus.mode), 1);
            check($sformatf("ode.n%0d.gap.pos", n), int'(bus.song_pos), n);
            check($sformatf("ode.n%0d.gap.done", n), int'(bus.done), 0);
        end
        tick();
        check("ode.end.done", int'(bus.done), 1);
        check("ode.end.mode", int'(bus.mode), 0);
        check("ode.end.pos", int'(bus.song_pos), 0);
        tick();
        check("ode.after.done", int'(bus.done), 0);

        // DOREMI autoplay aborted mid-song.
        bus.DOREMI_AUTO = 1'b1;
        tick();
        bus.DOREMI_AUTO = 1'b0;
        check("dra.start.mode", int'(bus.mode), 1);
        check("dra.start.idx", int'(bus.note_idx), 0);
        check("dra.start.on", int'(bus.note_on), 1);
        repeat (6) tick();
        check("dra.mid.pos", int'(bus.song_pos), 1);
        check("dra.mid.mode", int'(bus.mode), 1);
        bus.DOREMI_AUTO = 1'b1;
        tick();
        bus.DOREMI_AUTO = 1'b0;
        check("abort.mode", int'(bus.mode), 0);
        check("abort.on", int'(bus.note_on), 0);
        check("abort.pos", int'(bus.song_pos), 0);
        check("abort.done", int'(bus.done), 0);
        tick();
        check("abort2.mode", int'(bus.mode), 0);
        check("abort2.done", int'(bus.done), 0);

        // Learn mode.
        bus.DOREMI_LEARN = 1'b1;
        tick();
        bus.DOREMI_LEARN = 1'b0;
        check("lrn.start.mode", int'(bus.mode), 2);
        check("lrn.start.pos", int'(bus.song_pos), 0);
        check("lrn.start.expect", int'(bus.expect_idx), 0);
        bus.sw = 8'h80;
        tick();
        check("lrn.c.ok", int'(bus.learn_ok), 1);
        check("lrn.c.pos", int'(bus.song_pos), 1);
        check("lrn.c.expect", int'(bus.expect_idx), 1);
        check("lrn.c.on", int'(bus.note_on), 1);
        check("lrn.c.idx", int'(bus.note_idx), 0);
        bus.sw = 8'h00;
        tick();
        check("lrn.rel1.ok", int'(bus.learn_ok), 0);
        bus.sw = 8'h40;
        tick();
        check("lrn.d.ok", int'(bus.learn_ok), 1);
        check("lrn.d.pos", int'(bus.song_pos), 2);
        check("lrn.d.expect", int'(bus.expect_idx), 2);
        bus.sw = 8'h00;
        tick();

        // Wrong key, then a held-key change that must not count as a press.
        bus.sw = 8'h10;
        tick();
        check("lrn.f.err", int'(bus.learn_err), 1);
        check("lrn.f.ok", int'(bus.learn_ok), 0);
        check("lrn.f.pos", int'(bus.song_pos), 2);
        check("lrn.f.idx", int'(bus.note_idx), 3);
        tick();
        check("lrn.fheld.err", int'(bus.learn_err), 0);
        check("lrn.fheld.idx", int'(bus.note_idx), 3);
        check("lrn.fheld.on", int'(bus.note_on), 1);
        bus.sw = 8'h20;
        tick();
        check("lrn.chg.ok", int'(bus.learn_ok), 0);
        check("lrn.chg.err", int'(bus.learn_err), 0);
        check("lrn.chg.pos", int'(bus.song_pos), 2);
        check("lrn.chg.idx", int'(bus.note_idx), 2);
        bus.sw = 8'h00;
        tick();

        // Play the rest of Do-Re-Mi correctly through completion.
        for (int n = 2; n < 14; n++) begin
            bus.sw = 8'h80 >> dre_tbl[n];
            tick();
            check($sformatf("lrn.n%0d.ok", n), int'(bus.learn_ok), 1);
            check($sformatf("lrn.n%0d.done", n), int'(bus.done), (n == 13) ? 1 : 0);
            check($sformatf("lrn.n%0d.pos", n), int'(bus.song_pos), (n == 13) ? 0 : n + 1);
            check($sformatf("lrn.n%0d.mode", n), int'(bus.mode), (n == 13) ? 0 : 2);
            check($sformatf("lrn.n%0d.expect", n), int'(bus.expect_idx),
                  (n == 13) ? 0 : dre_tbl[n + 1]);
            bus.sw = 8'h00;
            tick();
            check($sformatf("lrn.n%0d.rel.ok", n), int'(bus.learn_ok), 0);
            check($sformatf("lrn.n%0d.rel.done", n), int'(bus.done), 0);
        end

        // Reset mid-autoplay with the button held through release.
        bus.ODE_TO_JOY_AUTO = 1'b1;
        tick();
        bus.ODE_TO_JOY_AUTO = 1'b0;
        for (int i = 0; i < 100 && int'(bus.song_pos) != 7; i++) tick();
        check("rst.reach.pos", int'(bus.song_pos), 7);
        rst_n = 1'b0;
        bus.ODE_TO_JOY_AUTO = 1'b1;
        tick();
        check_idle_reset("rst.mid");
        tick();
        rst_n = 1'b1;
        tick();
        check("rst.rel.mode", int'(bus.mode), 1);
        check("rst.rel.on", int'(bus.note_on), 1);
        check("rst.rel.idx", int'(bus.note_idx), 2);
        check("rst.rel.pos", int'(bus.song_pos), 0);
        bus.ODE_TO_JOY_AUTO = 1'b0;
        tick();
        check("rst.rel2.mode", int'(bus.mode), 1);
        check("rst.rel2.done", int'(bus.done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
